sine_pwm_multi: RTL and testbench
=================================

# sine_pwm_multi

Parametrised multi-channel sine-modulated PWM generator, the successor to the single-channel width/counter/comparator sine block. It drives CHANNELS PWM outputs from one shared period counter. Each channel's duty is read from a sine lookup table at an evenly spaced phase offset. Duties update glitch-free only at period boundaries, and the phase rate is runtime-programmable. It sits after the PLL in the fast clock domain and feeds pads or a downstream filter.

## Interface
- `CHANNELS`, 4: number of PWM channels; must be ≥1 and divide `LUT_DEPTH`.
- `PERIOD`, 1000: PWM period in clocks; must be ≥4.
- `CNT_W`, 10: counter/duty width; requires 2^CNT_W > `PERIOD`.
- `LUT_DEPTH`, 64: sine samples per cycle; power of two.
- `PHASE_W`, 6: log2(`LUT_DEPTH`).
- `DEAD`, 8: dead-time clocks; used only with `SINE_PWM_DEADTIME_EN`; must be < `PERIOD`/2.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable.
- `step`  in  `PHASE_W`  phase increment per PWM period; sampled at wrap.
- `pwm`  out  `CHANNELS`  PWM outputs, registered.
- `pwm_n`  out  `CHANNELS`  complementary outputs; present only with `SINE_PWM_DEADTIME_EN`.
- `period_tick`  out  1  one-cycle pulse marking a new period.

## Operation
- `cnt` counts 0..`PERIOD`-1. At `PERIOD`-1 with `en`=1, the next value is 0; this is a wrap.
- `phase` (`PHASE_W` bits) updates at each wrap: `phase` <= (`phase` + `step`) mod `LUT_DEPTH`. It wraps silently.
- Channel offset: off[c] = c·`LUT_DEPTH`/`CHANNELS`.
- `duty_next[c]` is a register loaded every cycle with LUT[(`phase` + off[c]) mod `LUT_DEPTH`].
- LUT[k] = round(`PERIOD`/2·(1 + sin(2πk/`LUT_DEPTH`))), giving a range of 0..`PERIOD`.
- `duty_act[c]` loads `duty_next[c]` only on a wrap edge. It is never loaded mid-period.
- Raw compare: r[c] = (`cnt` < `duty_act[c]`).
  - Duty 0 gives constant low.
  - Duty `PERIOD` gives constant high.
- Period n (n=0 is the first period after reset) uses LUT(((n−1)·`step` + off) mod `LUT_DEPTH`). Period 0 has duty 0, so all outputs are low.
- `en`=0:
  - `cnt` is forced to 0.
  - `pwm` and `pwm_n` are forced to 0.
  - `phase` and `duty_act` hold.
  - No `period_tick` is issued.
- Re-enable starts counting from 0 using the held `duty_act`, with no load.
- `en` dropping in the same cycle as a wrap suppresses the wrap: no load, no `phase` step.
- A change to `step` mid-period takes effect at the next wrap only.

## Timing
- Reset values: `cnt`=0, `phase`=0, `duty_next`=0, `duty_act`=0, `pwm`=0, `pwm_n`=0, `period_tick`=0.
- `pwm[c]` at cycle t+1 = r[c] evaluated with `cnt` at cycle t. Latency is one clock.
- `period_tick`=1 exactly in the cycle where `cnt`=0 following a wrap. It is not asserted on the first count after reset or after re-enable.
- `duty_next` settles one cycle after `phase` changes. `PERIOD`≥4 guarantees it is stable before the next wrap.
- Reset mid-period clears everything immediately (asynchronous assert). Release is synchronous to `clk`.

## Configuration
- `SINE_PWM_DEADTIME_EN` defined:
  - `pwm_n` and `DEAD` exist.
  - `pwm[c]` rises only after r[c] has been 1 for `DEAD` consecutive cycles, and falls with r[c] (same one-cycle latency).
  - `pwm_n[c]` follows the same rule applied to ~r[c].
  - `pwm` and `pwm_n` are never simultaneously 1.
  - The per-channel dead counters reset to 0 on `rst_n` or `en`=0.
- Macro undefined: no `pwm_n` port, no dead logic, `pwm` = registered r.

## Structure
- Shared package `sine_pwm_pkg`:
  - LUT generator function `sine_lut_val(k, depth, period)`.
  - Parameter legality checks.
  - Channel offset function.
- One sub-module, `sine_pwm_chan`, instantiated per channel. It contains the `duty_next`/`duty_act` registers, the compare, the output register and the optional dead-time logic.
- The top level holds `cnt`, `phase`, `period_tick` and the LUT ROM. The ROM is elaborated from the package function.

## Test plan
- Defaults, `step`=1, `en`=1 after reset release:
  - Period 0: all `pwm` are 0.
  - Period 1: ch0 high 500 clocks, ch1 high 1000 clocks, ch2 high 500 clocks, ch3 high 0 clocks.
- `step`=16, observed over 5 periods: ch0 high counts are 0, 500, 1000, 500, 0 in periods 0–4.
- `step` changed mid-period, `en` pulsed low 3 cycles mid-period:
  - New `step` applies only after the next wrap.
  - `pwm` is 0 one cycle after `en` falls.
  - `cnt` restarts at 0.
  - No `period_tick` on the restart.
- `rst_n` asserted at `cnt`=700: all outputs are 0 immediately. After release the sequence restarts at period 0.
- `SINE_PWM_DEADTIME_EN`, `DEAD`=8, duty 500:
  - `pwm` high 492 clocks per period.
  - `pwm_n` high 492 clocks per period.
  - The overlap check (`pwm` & `pwm_n`) never fires.
- `PERIOD`=7, `CNT_W`=3, `CHANNELS`=1: duty extremes 0 and 7 give constant low and constant high, and `period_tick` has period 7.

Source files
------------

// File: rtl/sine_pwm_pkg.sv
// rtl/sine_pwm_pkg.sv - shared sine LUT generator, channel offsets and parameter legality checks
package sine_pwm_pkg;

    localparam real SINE_PI = 3.14159265358979323846;
    localparam int  SINE_TAYLOR_TERMS = 10;

    // Quadrant folding keeps the series on [0, pi/2] and makes the 0/90/180/270 degree points exact.
    function automatic int sine_lut_val(input int k, input int depth, input int period);
        int  kk;
        bit  neg;
        real x;
        real term;
        real s;
        real v;
        kk  = k % depth;
        neg = 1'b0;
        if (kk >= depth / 2) begin
            neg = 1'b1;
            kk  = kk - depth / 2;
        end
        if (kk > depth / 4) begin
            kk = depth / 2 - kk;
        end
        x    = 2.0 * SINE_PI * kk / depth;
        term = x;
        s    = x;
        for (int n = 1; n < SINE_TAYLOR_TERMS; n++) begin
            term = -term * x * x / ((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        if (neg) begin
            s = -s;
        end
        v = period * (1.0 + s) / 2.0;
        return $rtoi(v + 0.5);
    endfunction

    function automatic int chan_offset(input int c, input int depth, input int channels);
        return (c * depth) / channels;
    endfunction

    function automatic bit sine_params_ok(input int channels, input int period, input int cnt_w,
                                          input int lut_depth, input int phase_w);
        bit ok;
        ok = 1'b1;
        if (channels < 1) ok = 1'b0;
        if (period < 4) ok = 1'b0;
        if (cnt_w < 1 || cnt_w > 30) ok = 1'b0;
        else if ((1 << cnt_w) <= period) ok = 1'b0;
        if (lut_depth < 1 || (lut_depth & (lut_depth - 1)) != 0) ok = 1'b0;
        if (phase_w < 1 || phase_w > 30) ok = 1'b0;
        else if ((1 << phase_w) != lut_depth) ok = 1'b0;
        if (channels >= 1 && (lut_depth % channels) != 0) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit dead_ok(input int dead, input int period);
        return (dead >= 0) && (2 * dead < period);
    endfunction

endpackage

// File: rtl/sine_pwm_multi_chan.sv
// rtl/sine_pwm_multi_chan.sv - one PWM channel: duty double-buffer, compare, output register, optional dead time (SINE_PWM_DEADTIME_EN)
module sine_pwm_chan
    import sine_pwm_pkg::*;
#(
    parameter int CNT_W = 10
`ifdef SINE_PWM_DEADTIME_EN
    , parameter int DEAD = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wrap,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] lut_val,
    output logic             pwm
`ifdef SINE_PWM_DEADTIME_EN
    , output logic           pwm_n
`endif
);

    logic [CNT_W-1:0] duty_next_q, duty_next_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;
    logic             r;

    assign r   = cnt < duty_act_q;
    assign pwm = pwm_q;

    // wrap already includes en, so a wrap swallowed by en=0 never loads duty_act.
    always_comb begin
        duty_next_d = lut_val;
        duty_act_d  = wrap ? duty_next_q : duty_act_q;
    end

`ifdef SINE_PWM_DEADTIME_EN
    localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);

    logic [CNT_W-1:0] run_p_q, run_p_d;
    logic [CNT_W-1:0] run_n_q, run_n_d;
    logic             pwm_n_q, pwm_n_d;

    assign pwm_n = pwm_n_q;

    // Run counters hold the number of earlier consecutive cycles the raw level was stable, saturating at DEAD.
    always_comb begin
        run_p_d = '0;
        run_n_d = '0;
        if (en) begin
            if (r) begin
                run_p_d = (run_p_q == DEAD_C) ? run_p_q : run_p_q + 1'b1;
            end else begin
                run_n_d = (run_n_q == DEAD_C) ? run_n_q : run_n_q + 1'b1;
            end
        end
        pwm_d   = en && r && (run_p_q >= DEAD_C);
        pwm_n_d = en && !r && (run_n_q >= DEAD_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_p_q <= '0;
            run_n_q <= '0;
            pwm_n_q <= 1'b0;
        end else begin
            run_p_q <= run_p_d;
            run_n_q <= run_n_d;
            pwm_n_q <= pwm_n_d;
        end
    end
`else
    always_comb begin
        pwm_d = en && r;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_next_q <= '0;
            duty_act_q  <= '0;
            pwm_q       <= 1'b0;
        end else begin
            duty_next_q <= duty_next_d;
            duty_act_q  <= duty_act_d;
            pwm_q       <= pwm_d;
        end
    end

endmodule

// File: rtl/sine_pwm_multi.sv
// rtl/sine_pwm_multi.sv - multi-channel sine PWM top: period counter, phase accumulator, LUT ROM; dead time via SINE_PWM_DEADTIME_EN
module sine_pwm_multi
    import sine_pwm_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PERIOD    = 1000,
    parameter int CNT_W     = 10,
    parameter int LUT_DEPTH = 64,
    parameter int PHASE_W   = 6
`ifdef SINE_PWM_DEADTIME_EN
    , parameter int DEAD    = 8
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PHASE_W-1:0]  step,
    output logic [CHANNELS-1:0] pwm,
`ifdef SINE_PWM_DEADTIME_EN
    output logic [CHANNELS-1:0] pwm_n,
`endif
    output logic                period_tick
);

    if (!sine_params_ok(CHANNELS, PERIOD, CNT_W, LUT_DEPTH, PHASE_W)) begin : g_bad_params
        $error("sine_pwm_multi: illegal parameter combination");
    end
`ifdef SINE_PWM_DEADTIME_EN
    if (!dead_ok(DEAD, PERIOD)) begin : g_bad_dead
        $error("sine_pwm_multi: DEAD must be below PERIOD/2");
    end
`endif

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               tick_q, tick_d;
    logic               wrap;
    logic [CNT_W-1:0]   lut [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam int VAL = sine_lut_val(k, LUT_DEPTH, PERIOD);
        assign lut[k] = CNT_W'(VAL);
    end

    assign wrap        = en && (cnt_q == CNT_W'(PERIOD - 1));
    assign period_tick = tick_q;

    // en=0 parks the counter at 0 so re-enable starts a fresh period without a tick.
    always_comb begin
        cnt_d   = '0;
        phase_d = phase_q;
        tick_d  = wrap;
        if (en && !wrap) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (wrap) begin
            phase_d = phase_q + step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        localparam int OFF = chan_offset(c, LUT_DEPTH, CHANNELS);
        logic [PHASE_W-1:0] idx;

        assign idx = phase_q + PHASE_W'(OFF);

        sine_pwm_chan #(
            .CNT_W (CNT_W)
`ifdef SINE_PWM_DEADTIME_EN
            , .DEAD (DEAD)
`endif
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .wrap    (wrap),
            .cnt     (cnt_q),
            .lut_val (lut[idx]),
            .pwm     (pwm[c])
`ifdef SINE_PWM_DEADTIME_EN
            , .pwm_n (pwm_n[c])
`endif
        );
    end

endmodule

// File: tb/tb_sine_pwm_multi.sv
// tb/tb_sine_pwm_multi.sv - directed self-checking bench for sine_pwm_multi (default and SINE_PWM_DEADTIME_EN builds)
module tb_sine_pwm_multi;

    localparam int PER  = 1000;
    localparam int SPER = 7;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [5:0] step;
    logic [3:0] pwm;
    logic       period_tick;
    logic       rst2_n, en2;
    logic [5:0] step2;
    logic [0:0] s_pwm;
    logic       s_tick;
`ifdef SINE_PWM_DEADTIME_EN
    logic [3:0] pwm_n;
    logic [0:0] s_pwm_n;
    int         hi_n [4];
    logic       overlap;
`endif

    int   hi [4];
    int   ticks;
    logic tick_last;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sine_pwm_multi #(
        .CHANNELS (4), .PERIOD (PER), .CNT_W (10), .LUT_DEPTH (64), .PHASE_W (6)
`ifdef SINE_PWM_DEADTIME_EN
        , .DEAD (8)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .step        (step),
        .pwm         (pwm),
`ifdef SINE_PWM_DEADTIME_EN
        .pwm_n       (pwm_n),
`endif
        .period_tick (period_tick)
    );

    sine_pwm_multi #(
        .CHANNELS (1), .PERIOD (SPER), .CNT_W (3), .LUT_DEPTH (64), .PHASE_W (6)
`ifdef SINE_PWM_DEADTIME_EN
        , .DEAD (2)
`endif
    ) dut_small (
        .clk         (clk),
        .rst_n       (rst2_n),
        .en          (en2),
        .step        (step2),
        .pwm         (s_pwm),
`ifdef SINE_PWM_DEADTIME_EN
        .pwm_n       (s_pwm_n),
`endif
        .period_tick (s_tick)
    );

    task automatic run_window();
        for (int c = 0; c < 4; c++) begin
            hi[c] = 0;
`ifdef SINE_PWM_DEADTIME_EN
            hi_n[c] = 0;
`endif
        end
        ticks = 0;
        tick_last = 1'b0;
`ifdef SINE_PWM_DEADTIME_EN
        overlap = 1'b0;
`endif
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (pwm[c]) hi[c]++;
`ifdef SINE_PWM_DEADTIME_EN
                if (pwm_n[c]) hi_n[c]++;
                if (pwm[c] && pwm_n[c]) overlap = 1'b1;
`endif
            end
            if (period_tick) ticks++;
            tick_last = period_tick;
        end
    endtask

    task automatic do_reset(input logic [5:0] s);
        rst_n = 1'b0;
        en    = 1'b1;
        step  = s;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        step  = 6'd1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (pwm !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pwm: got %b expected %b", pwm, 4'b0000);
        end
        n_checks++;
        if (period_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_tick: got %b expected 0", period_tick);
        end
        n_checks++;
        if (dut.cnt_q !== 10'd0 || dut.phase_q !== 6'd0) begin
            n_fail++; $display("FAIL reset_state: got cnt %0d phase %0d expected 0 0", dut.cnt_q, dut.phase_q);
        end
    endtask

    task automatic test_step1();
        int exp_p1 [4] = '{500, 1000, 500, 0};
        do_reset(6'd1);
        run_window();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (hi[c] !== 0) begin
                n_fail++; $display("FAIL step1_p0_ch%0d: got %0d high expected 0", c, hi[c]);
            end
        end
        n_checks++;
        if (ticks !== 1 || tick_last !== 1'b1) begin
            n_fail++; $display("FAIL step1_p0_tick: got %0d ticks last %b expected 1 ticks last 1", ticks, tick_last);
        end
        run_window();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (hi[c] !== exp_p1[c]) begin
                n_fail++; $display("FAIL step1_p1_ch%0d: got %0d high expected %0d", c, hi[c], exp_p1[c]);
            end
        end
    endtask

    task automatic test_step16();
        int quad [4] = '{500, 1000, 500, 0};
        int exp;
        do_reset(6'd16);
        for (int n = 0; n < 5; n++) begin
            run_window();
            for (int c = 0; c < 4; c++) begin
                exp = (n == 0) ? 0 : quad[(n - 1 + c) % 4];
                n_checks++;
                if (hi[c] !== exp) begin
                    n_fail++; $display("FAIL step16_p%0d_ch%0d: got %0d high expected %0d", n, c, hi[c], exp);
                end
            end
            n_checks++;
            if (ticks !== 1 || tick_last !== 1'b1) begin
                n_fail++; $display("FAIL step16_p%0d_tick: got %0d ticks last %b expected 1 ticks last 1", n, ticks, tick_last);
            end
        end
    endtask

    task automatic test_step_change();
        int h0;
        do_reset(6'd16);
        run_window();
        h0 = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            if (i == 299) step = 6'd32;
            if (pwm[0]) h0++;
        end
        n_checks++;
        if (h0 !== 500) begin
            n_fail++; $display("FAIL chg_p1_ch0: got %0d high expected 500", h0);
        end
        run_window();
        n_checks++;
        if (hi[0] !== 1000 || hi[2] !== 0) begin
            n_fail++; $display("FAIL chg_p2: got ch0 %0d ch2 %0d expected 1000 0", hi[0], hi[2]);
        end
        run_window();
        n_checks++;
        if (hi[0] !== 0 || hi[2] !== 1000) begin
            n_fail++; $display("FAIL chg_p3: got ch0 %0d ch2 %0d expected 0 1000", hi[0], hi[2]);
        end
        n_checks++;
        if (dut.phase_q !== 6'd48) begin
            n_fail++; $display("FAIL chg_phase: got %0d expected 48", dut.phase_q);
        end
    endtask

    // Continues from test_step_change: period 4 holds ch0=1000, ch2=0, phase 48.
    task automatic test_en_pulse();
        repeat (400) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (pwm !== 4'b0000 || period_tick !== 1'b0 || dut.cnt_q !== 10'd0) begin
                n_fail++; $display("FAIL en_low_%0d: got pwm %b tick %b cnt %0d expected 0000 0 0", k, pwm, period_tick, dut.cnt_q);
            end
        end
        n_checks++;
        if (dut.phase_q !== 6'd48) begin
            n_fail++; $display("FAIL en_low_phase: got %0d expected 48", dut.phase_q);
        end
        en = 1'b1;
        run_window();
        n_checks++;
        if (ticks !== 1 || tick_last !== 1'b1) begin
            n_fail++; $display("FAIL en_restart_tick: got %0d ticks last %b expected 1 ticks last 1", ticks, tick_last);
        end
        n_checks++;
        if (hi[0] !== 1000 || hi[2] !== 0) begin
            n_fail++; $display("FAIL en_restart_duty: got ch0 %0d ch2 %0d expected 1000 0", hi[0], hi[2]);
        end
        run_window();
        n_checks++;
        if (hi[0] !== 0 || hi[2] !== 1000) begin
            n_fail++; $display("FAIL en_next_p: got ch0 %0d ch2 %0d expected 0 1000", hi[0], hi[2]);
        end
    endtask

    task automatic test_en_at_wrap();
        repeat (999) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (period_tick !== 1'b0 || dut.phase_q !== 6'd48 || dut.cnt_q !== 10'd0) begin
            n_fail++; $display("FAIL wrap_suppress: got tick %b phase %0d cnt %0d expected 0 48 0", period_tick, dut.phase_q, dut.cnt_q);
        end
        en = 1'b1;
        run_window();
        n_checks++;
        if (hi[0] !== 1000 || ticks !== 1) begin
            n_fail++; $display("FAIL wrap_held_duty: got ch0 %0d ticks %0d expected 1000 1", hi[0], ticks);
        end
        n_checks++;
        if (dut.phase_q !== 6'd16) begin
            n_fail++; $display("FAIL wrap_phase_after: got %0d expected 16", dut.phase_q);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(6'd16);
        run_window();
        repeat (700) @(negedge clk);
        n_checks++;
        if (pwm[1] !== 1'b1 || dut.cnt_q !== 10'd700) begin
            n_fail++; $display("FAIL rmid_pre: got pwm1 %b cnt %0d expected 1 700", pwm[1], dut.cnt_q);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (pwm !== 4'b0000 || period_tick !== 1'b0 || dut.cnt_q !== 10'd0 || dut.phase_q !== 6'd0) begin
            n_fail++; $display("FAIL rmid_async: got pwm %b tick %b cnt %0d phase %0d expected 0000 0 0 0", pwm, period_tick, dut.cnt_q, dut.phase_q);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_window();
        n_checks++;
        if (hi[0] !== 0 || hi[1] !== 0 || hi[2] !== 0 || hi[3] !== 0) begin
            n_fail++; $display("FAIL rmid_p0: got %0d %0d %0d %0d expected 0 0 0 0", hi[0], hi[1], hi[2], hi[3]);
        end
        run_window();
        n_checks++;
        if (hi[0] !== 500 || hi[1] !== 1000) begin
            n_fail++; $display("FAIL rmid_p1: got ch0 %0d ch1 %0d expected 500 1000", hi[0], hi[1]);
        end
    endtask

    task automatic test_small();
        int exp_s [5] = '{0, 4, 7, 4, 0};
        int sh;
        int st;
        logic slast;
        rst2_n = 1'b0;
        en2    = 1'b1;
        step2  = 6'd16;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            sh = 0;
            st = 0;
            slast = 1'b0;
            for (int i = 0; i < SPER; i++) begin
                @(negedge clk);
                if (s_pwm[0]) sh++;
                if (s_tick) st++;
                slast = s_tick;
            end
`ifndef SINE_PWM_DEADTIME_EN
            n_checks++;
            if (sh !== exp_s[n]) begin
                n_fail++; $display("FAIL small_p%0d_high: got %0d expected %0d", n, sh, exp_s[n]);
            end
`endif
            n_checks++;
            if (st !== 1 || slast !== 1'b1) begin
                n_fail++; $display("FAIL small_p%0d_tick: got %0d ticks last %b expected 1 ticks last 1", n, st, slast);
            end
        end
    endtask

`ifdef SINE_PWM_DEADTIME_EN
    task automatic test_deadtime();
        logic any_overlap;
        do_reset(6'd16);
        run_window();
        any_overlap = overlap;
        run_window();
        any_overlap = any_overlap | overlap;
        n_checks++;
        if (hi[0] !== 492 || hi_n[0] !== 492) begin
            n_fail++; $display("FAIL dead_ch0: got pwm %0d pwm_n %0d expected 492 492", hi[0], hi_n[0]);
        end
        n_checks++;
        if (hi[2] !== 492 || hi_n[2] !== 492) begin
            n_fail++; $display("FAIL dead_ch2: got pwm %0d pwm_n %0d expected 492 492", hi[2], hi_n[2]);
        end
        n_checks++;
        if (any_overlap !== 1'b0) begin
            n_fail++; $display("FAIL dead_overlap: got %b expected 0", any_overlap);
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        en     = 1'b0;
        en2    = 1'b0;
        step   = '0;
        step2  = '0;
        #2;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        test_reset();
`ifdef SINE_PWM_DEADTIME_EN
        test_deadtime();
`else
        test_step1();
        test_step16();
        test_step_change();
        test_en_pulse();
        test_en_at_wrap();
        test_reset_mid();
`endif
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
